// File: rtl/mmio_fifo_responder.sv
// mmio_fifo_responder: 4-word MMIO window bridging the CPU to TX/RX stream FIFOs.
// Optional irq output is enabled by defining MMIO_FIFO_IRQ_EN.
module mmio_fifo_responder #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 6'h3C,
    parameter int                    DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
`ifdef MMIO_FIFO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [PW-1:0]         tx_wr, tx_rd, rx_wr, rx_rd;
    logic [PW-1:0]         tx_count, rx_count;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_ovf, rx_udf, irq_en;

    logic                  sel;
    logic [1:0]            offset;
    logic                  tx_wr_req, ctrl_wr;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  tx_flush, rx_flush, clr_sticky;
    logic                  ovf_set, udf_set;
    logic [DATA_WIDTH-1:0] rx_head, status, rdata;
    logic                  unused_data;

    assign unused_data = ^data[DATA_WIDTH-1:5];

    assign sel    = (addr[ADDR_WIDTH-1:2] == BASE[ADDR_WIDTH-1:2]);
    assign offset = addr[1:0];

    // Pointer-based occupancy: equal means empty, MSB-only difference means full.
    assign tx_empty = (tx_wr == tx_rd);
    assign rx_empty = (rx_wr == rx_rd);
    assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) &&
                      (tx_wr[PW-2:0] == tx_rd[PW-2:0]);
    assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) &&
                      (rx_wr[PW-2:0] == rx_rd[PW-2:0]);
    assign tx_count = tx_wr - tx_rd;
    assign rx_count = rx_wr - rx_rd;

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign tx_data  = tx_empty ? '0 : tx_mem[tx_rd[PW-2:0]];
    assign rx_head  = rx_empty ? '0 : rx_mem[rx_rd[PW-2:0]];

    assign tx_wr_req  = we && sel && (offset == 2'd0);
    assign ctrl_wr    = we && sel && (offset == 2'd2);
    assign clr_sticky = ctrl_wr && data[0];
    assign tx_flush   = ctrl_wr && data[1];
    assign rx_flush   = ctrl_wr && data[2];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_pop  = tx_valid && tx_ready;
    assign tx_push = tx_wr_req && (!tx_full || tx_pop);
    assign ovf_set = tx_wr_req && tx_full && !tx_pop;
    assign rx_push = rx_valid && rx_ready;
    assign rx_pop  = ctrl_wr && data[3] && !rx_empty;
    assign udf_set = ctrl_wr && data[3] && rx_empty;

    // Assemble the register view of the current state.
    always_comb begin
        status      = DATA_WIDTH'(rx_count) << 8;
        status[5:0] = {rx_udf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
        rdata       = '0;
        unique case (offset)
            2'd0: rdata = DATA_WIDTH'(tx_count);
            2'd1: rdata = status;
            2'd2: rdata = DATA_WIDTH'(irq_en);
            2'd3: rdata = rx_head;
            default: rdata = '0;
        endcase
    end

    // Registered read port with one-cycle latency, like the memory beside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            hit <= 1'b0;
        end else begin
            out <= sel ? rdata : '0;
            hit <= sel;
        end
    end

    // TX pointers; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
        end
    end

    // RX pointers; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
        end
    end

    // FIFO storage; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[PW-2:0]] <= data;
        if (rx_push) rx_mem[rx_wr[PW-2:0]] <= rx_data;
    end

    // Sticky error flags and irq enable; a new event beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            tx_ovf <= ovf_set || (tx_ovf && !clr_sticky);
            rx_udf <= udf_set || (rx_udf && !clr_sticky);
            if (ctrl_wr) irq_en <= data[4];
        end
    end

`ifdef MMIO_FIFO_IRQ_EN
    // Level interrupt that follows its causes one edge later.
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= irq_en && (!rx_empty || tx_ovf || rx_udf);
    end
`endif

endmodule

// File: doc/mmio_fifo_responder.md
Name: mmio_fifo_responder

Overview:
- Memory-mapped responder on the CPU data-memory bus (mem_we / mem_addr / mem_data out, mem_in back), sitting beside memory.
- Claims a 4-word window at BASE. Top-level decodes `hit` to steer mem_in between memory and this block.
- Bridges the CPU to a streaming peripheral through a TX FIFO (CPU→peripheral) and an RX FIFO (peripheral→CPU), each with valid/ready handshakes.
- All CPU reads are side-effect free.

Parameters:
- ADDR_WIDTH, 6, CPU address width.
- DATA_WIDTH, 16, CPU data width; must be ≥ 8.
- BASE, 6'h3C, window base address; must be 4-aligned.
- DEPTH_LOG2, 2, log2 of each FIFO's depth (default depth 4). Range 1..5.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  CPU write strobe
- addr  in  ADDR_WIDTH  CPU address
- data  in  DATA_WIDTH  CPU write data
- out  out  DATA_WIDTH  read data, registered
- hit  out  1  registered: addr of the previous cycle was inside the window
- tx_data  out  DATA_WIDTH  head of TX FIFO
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  peripheral accepts tx_data
- rx_data  in  DATA_WIDTH  peripheral word
- rx_valid  in  1  peripheral offers rx_data
- rx_ready  out  1  RX FIFO not full

Behaviour:
- Reset (rst=1 at a clk edge): both FIFOs empty, pointers 0, sticky flags 0, out=0, hit=0, CTRL.irq_en=0, tx_valid=0, rx_ready=1, tx_data=0.
- Decode: sel = (addr[ADDR_WIDTH-1:2] == BASE[ADDR_WIDTH-1:2]); offset = addr[1:0].
- Read latency is 1 cycle, matching memory: out and hit update at each edge from the current addr. Outside the window, out=0 and hit=0.
- Offset 0, TXDATA:
  - Write pushes data into the TX FIFO.
  - If the TX FIFO is full, the word is dropped and tx_ovf is set (sticky).
  - Read returns the TX occupancy count.
- Offset 1, STATUS (read-only; writes ignored):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_ovf, bit5 rx_udf.
  - [DATA_WIDTH-1:8] = RX occupancy count; other bits 0.
- Offset 2, CTRL (write-only action bits; read returns {0, irq_en}):
  - bit0 clears tx_ovf and rx_udf.
  - bit1 flushes TX.
  - bit2 flushes RX.
  - bit3 pops RX. If RX is empty, nothing is popped and rx_udf is set.
  - bit4 stores irq_en.
- Offset 3, RXPEEK: read returns the RX head, or 0 if RX is empty. Writes ignored.
- Peripheral side:
  - TX pops when tx_valid && tx_ready.
  - RX pushes when rx_valid && rx_ready.
  - tx_data is combinational from the head entry.
- Simultaneous events:
  - TX push + pop in one cycle with TX full: both occur, count unchanged, no overflow.
  - TX push + pop with TX empty: the pop is blocked (tx_valid=0), the push lands, count becomes 1.
  - RX push + CPU pop with RX full: the push is blocked (rx_ready=0), the pop occurs.
  - Flush in the same cycle as a push to the same FIFO: flush wins and the FIFO ends empty.
  - Clear-sticky in the same cycle as a new overflow/underflow: the set wins.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2·depth. Full = MSBs differ and the rest is equal.
- Reset mid-transfer discards all contents with no partial handshakes. tx_valid drops in the cycle after the reset edge.

Optional Feature:
- Macro: MMIO_FIFO_IRQ_EN.
- Defined: adds output port `irq` (1 bit, registered, reset 0). irq = irq_en && (!rx_empty || tx_ovf || rx_udf), updated each edge; it clears only when the causes are removed.
- Undefined: no irq port; CTRL bit4 still stores irq_en and reads back, with no other effect.

Test Plan:
- Reset, then read STATUS at 0x3D → one cycle later out=16'h000A (tx_empty, rx_empty), hit=1. Read 0x10 → out=0, hit=0.
- tx_ready=0; write 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 to 0x3C → STATUS bit0=1, bit4=1; tx_data=16'h1111. Raise tx_ready for 4 cycles → 1111, 2222, 3333, 4444 emitted in order, then tx_valid=0.
- Peripheral pushes 0xABCD, 0x0042. Read 0x3F twice → 0xABCD both times (no pop). Write CTRL=8 → next 0x3F read gives 0x0042; STATUS[15:8]=1.
- RX empty; write CTRL=8 → STATUS bit5=1. Write CTRL=1 → bits 4 and 5 clear.
- Fill RX to 4 (rx_ready=0); in one cycle hold rx_valid=1 and write CTRL=8 → count 3, no push. Next cycle rx_ready=1 and the push lands, count 4.
- With MMIO_FIFO_IRQ_EN defined: CTRL=16, peripheral pushes 1 word → irq=1 on the following edge. Write CTRL=8|16 → irq=0 one cycle after the pop.
